// File: rtl/trainer_pkg.sv
// Shared constants and types for the trainer sweep controller.
// Holds gate-select encodings, FSM state enum and the golden truth tables.
package trainer_pkg;

    localparam int unsigned GSEL_W  = 3;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned TABLE_W = 4;
    localparam int unsigned GATE_W  = 7;

    localparam logic [GSEL_W-1:0] GATE_AND   = 3'd0;
    localparam logic [GSEL_W-1:0] GATE_OR    = 3'd1;
    localparam logic [GSEL_W-1:0] GATE_NOT_A = 3'd2;
    localparam logic [GSEL_W-1:0] GATE_NAND  = 3'd3;
    localparam logic [GSEL_W-1:0] GATE_NOR   = 3'd4;
    localparam logic [GSEL_W-1:0] GATE_XOR   = 3'd5;
    localparam logic [GSEL_W-1:0] GATE_XNOR  = 3'd6;
    localparam logic [GSEL_W-1:0] GATE_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_CAPTURE,
        ST_CHECK
    } state_t;

    // Expected table per gate, bit index = {a,b}; reserved entry is all zero.
    localparam logic [TABLE_W-1:0] GOLDEN [8] = '{
        4'b1000,  // AND
        4'b1110,  // OR
        4'b0011,  // NOT_A
        4'b0111,  // NAND
        4'b0001,  // NOR
        4'b0110,  // XOR
        4'b1001,  // XNOR
        4'b0000   // reserved
    };

endpackage

// File: rtl/trainer_dwell_timer.sv
// Dwell counter for the sweep controller.
// Ports: clk, rst_n (sync, active-low), ena (global freeze), load (latch
// terminal value from dwell, 0 treated as 1), dwell, clr (count to 0),
// inc (count up), tc_c (count has reached terminal value).
module trainer_dwell_timer #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               load,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               clr,
    input  logic               inc,
    output logic               tc_c
);

    logic [DWELL_W-1:0] count_q, count_d;
    logic [DWELL_W-1:0] term_q,  term_d;

    // Next count and terminal value; clear wins over increment.
    always_comb begin
        count_d = count_q;
        term_d  = term_q;
        if (load) begin
            term_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        end
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            term_q  <= '0;
        end else if (ena) begin
            count_q <= count_d;
            term_q  <= term_d;
        end
    end

    assign tc_c = (count_q == term_q);

endmodule

// File: rtl/trainer_sweep_controller.sv
// Sweeps a two-input gate datapath through {a,b}=00,01,10,11, captures the
// selected gate output into a truth table and checks it against the golden
// table for that gate.
// Ports: clk, rst_n (sync, active-low), ena (freeze when low), start,
// step_mode (0 auto / 1 manual), step, gate_sel, dwell, gate_out (datapath
// outputs) -> a, b (datapath drive), busy, done (1-cycle pulse), pass, err,
// table_out (captured table, bit index = {a,b}).
module trainer_sweep_controller
    import trainer_pkg::*;
#(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic [GSEL_W-1:0]  gate_sel,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [GATE_W-1:0]  gate_out,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               err,
    output logic [TABLE_W-1:0] table_out
);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [GSEL_W-1:0]    gsel_q, gsel_d;
    logic                 mode_q, mode_d;
    logic                 step_prev_q, step_prev_d;
    logic                 a_q, a_d;
    logic                 b_q, b_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 err_q, err_d;
    logic [TABLE_W-1:0]   table_q, table_d;

    logic                 tmr_load;
    logic                 tmr_clr;
    logic                 tmr_inc;
    logic                 tmr_tc;
    logic                 step_edge;
    logic [GATE_W:0]      gate_ext;

    // Pad to 8 entries so every gsel value indexes in range.
    assign gate_ext  = {1'b0, gate_out};
    assign step_edge = step & ~step_prev_q;

    trainer_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .load  (tmr_load),
        .dwell (dwell),
        .clr   (tmr_clr),
        .inc   (tmr_inc),
        .tc_c  (tmr_tc)
    );

    // Next-state, capture and output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gsel_d      = gsel_q;
        mode_d      = mode_q;
        step_prev_d = step;
        a_d         = a_q;
        b_d         = b_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_d       = err_q;
        table_d     = table_q;
        tmr_load    = 1'b0;
        tmr_clr     = 1'b0;
        tmr_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gsel_d   = gate_sel;
                    mode_d   = step_mode;
                    table_d  = '0;
                    pass_d   = 1'b0;
                    idx_d    = '0;
                    a_d      = 1'b0;
                    b_d      = 1'b0;
                    tmr_load = 1'b1;
                    tmr_clr  = 1'b1;
                    err_d    = (gate_sel == GATE_RSVD);
                    state_d  = (gate_sel == GATE_RSVD) ? ST_CHECK : ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (mode_q) begin
                    if (step_edge) begin
                        state_d = ST_CAPTURE;
                    end
                end else if (tmr_tc) begin
                    state_d = ST_CAPTURE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_CAPTURE: begin
                table_d[idx_q] = gate_ext[gsel_q];
                tmr_clr        = 1'b1;
                if (idx_q == IDX_W'(3)) begin
                    state_d = ST_CHECK;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    {a_d, b_d} = idx_q + IDX_W'(1);
                    state_d    = ST_APPLY;
                end
            end
            ST_CHECK: begin
                pass_d  = ~err_q & (table_q == GOLDEN[gsel_q]);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State register; ena low freezes everything, including done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            gsel_q      <= '0;
            mode_q      <= 1'b0;
            step_prev_q <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 1'b0;
            table_q     <= '0;
        end else if (ena) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gsel_q      <= gsel_d;
            mode_q      <= mode_d;
            step_prev_q <= step_prev_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            table_q     <= table_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err       = err_q;
    assign table_out = table_q;

endmodule

// File: doc/trainer_sweep_controller.md
# trainer_sweep_controller

Sequencer and self-checker for the digital trainer kit's two-input gate datapath. On a start request it drives the gate inputs `a`/`b` through all four combinations, holding each for a programmable dwell time or until a manual step. It captures the selected gate output into a 4-bit truth table and compares that table against the golden table for the gate. It sits between the board's switch/button interface and `tt_um_digital_trainer_kit`.

## Interface
- `DWELL_W`, default 16: width of the dwell-count input and internal timer.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ena` in 1: global enable; low freezes all state and outputs.
- `start` in 1: level, sampled in IDLE; begins a sweep.
- `step_mode` in 1: 0 = auto (dwell timer), 1 = manual (`step` rising edge); latched at start.
- `step` in 1: manual advance, synchronous to `clk` (synchronizer lives outside this block).
- `gate_sel` in 3: 0 AND, 1 OR, 2 NOT_A, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved; latched at start.
- `dwell` in DWELL_W: cycles per vector in auto mode; 0 treated as 1; latched at start.
- `gate_out` in 7: datapath outputs {xnor, xor, nor, nand, not_a, or, and}, bits 6..0.
- `a`, `b` out 1 each: registered drive to the datapath.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at sweep end.
- `pass` out 1: captured table equals golden; held until next accepted start.
- `err` out 1: reserved `gate_sel` at start; held until next accepted start.
- `table_out` out 4: captured truth table, bit index = {a,b}; held until next accepted start.

## Operation
- Reset: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err`=0, `table_out`=0, state IDLE, idx=0, timer=0.
- States: IDLE, APPLY, CAPTURE, CHECK.
- **IDLE:** on `start`=1 with `ena`=1:
  - Latch `gate_sel`, `step_mode`, `dwell`.
  - Clear `table_out`, `pass` and `err`; set idx=0.
  - If `gate_sel`=7: go to CHECK directly with `err` set.
  - Otherwise go to APPLY.
- **APPLY:** `{a,b}`=idx.
  - Auto mode: the timer counts from 0; at count = max(dwell,1)−1 go to CAPTURE.
  - Manual mode: stay until a `step` rising edge (step=1 this cycle, 0 the previous cycle); then go to CAPTURE. The dwell value is ignored.
- **CAPTURE:** `table_out[idx]` ← `gate_out[gsel]`; `a`/`b` stay held.
  - If idx=3: go to CHECK.
  - Otherwise idx+1 and go to APPLY, with the timer cleared.
- **CHECK:** `pass` ← (¬err ∧ table_out == GOLDEN[gsel]); go to IDLE with `done`=1 for exactly that one IDLE cycle.
- Golden tables, bits 3..0 for {a,b}=11,10,01,00:
  - AND 1000, OR 1110, NOT_A 0011, NAND 0111
  - NOR 0001, XOR 0110, XNOR 1001
- Boundary rules:
  - `start` while busy: ignored.
  - `start` held high through a sweep: starts a new sweep on the first IDLE cycle after `done`.
  - `gate_sel`, `dwell` or `step_mode` changes mid-sweep: ignored.
  - Step edges outside APPLY: ignored, but the previous-step register keeps updating.
  - `ena`=0: state, timer, idx and outputs hold; `done` stays at its current value. Resuming continues exactly where the sweep stopped.
  - `rst_n`=0 mid-sweep: reset values at the next edge; the partial table is discarded.

## Timing
- Auto mode, D = max(dwell,1): vector k (0..3) enters APPLY at edge k(D+1) after the start-sampling edge. APPLY lasts D cycles and CAPTURE lasts 1 cycle.
- CHECK is entered at edge 4(D+1). `done`/`pass` are visible after edge 4(D+1)+1, e.g. 9 cycles for D=1.
- Reserved `gate_sel`: `done` 2 cycles after the start edge.
- `gate_out` is sampled at least D cycles after `a`/`b` change, so the datapath gets a full clock period to settle.
- No combinational path from any input to any output.

## Structure
- Package `trainer_pkg`:
  - Gate-select constants (GATE_AND..GATE_XNOR, GATE_RSVD=7).
  - State enum.
  - GOLDEN 8×4 constant array, with the RSVD entry 0000.
- Sub-module `trainer_dwell_timer`: loadable DWELL_W counter with clear, enable and terminal-count flag.
- FSM, step edge detect and capture logic stay in the top module.

## Test plan
- Reset, then auto mode, gate_sel=0 (AND), dwell=3: a/b sequence 00,01,10,11, each held for 3 cycles; `done` 17 cycles after start; `table_out`=1000, `pass`=1.
- Sweep gate_sel 1..6 with a correct datapath model: tables 1110, 0011, 0111, 0001, 0110, 1001, all with `pass`=1; with `gate_out[5]` forced to 0, XOR gives table 0000 and `pass`=0.
- Manual mode with step pulses 20 cycles apart, plus an extra pulse injected during CAPTURE: exactly 4 captures and `done` after the 4th step. Holding step high without a new rising edge gives no advance.
- gate_sel=7 at start: `err`=1, `pass`=0, `done` 2 cycles after start, and `a`/`b` never leave 00.
- Mid-sweep disturbances:
  - `start` pulses and `gate_sel` changes mid-sweep: no effect.
  - `ena` low for 5 cycles in APPLY: timing stretched by exactly 5 cycles, same result.
  - `rst_n` low mid-sweep: all outputs at reset values on the next edge.
- dwell=0: behaves identically to dwell=1, with `done` 9 cycles after start.
